keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad and resolves one debounced key.
- Presents the key to the calculator core:
  - a BCD digit code, or
  - an operator code,
  - a `pressed` level, and
  - a single-cycle `released` strobe.
- Sits directly upstream of the calculator datapath. The core acts on `released` and samples `digits`/`opers` in that same cycle.

Parameters:
- SCAN_CYCLES, 50000, clock cycles each row is driven before COLS is sampled (1 ms at 50 MHz).
- DEBOUNCE_SCANS, 5, consecutive identical full-matrix scans needed to accept a press or a release.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- rst_n  input  1  synchronous, active-low reset.
- rows  output  4  row drive, active-low, exactly one bit low at a time.
- cols  input  4  column sense, asynchronous, pulled up; low means a key in the driven row is down.
- digits  output  4  BCD digit 0-9 of the latched key; 0 when the latched key is an operator.
- opers  output  4  operator code of the latched key; 0 when the latched key is a digit.
- pressed  output  1  level; high while the latched key is considered held.
- released  output  1  one-cycle pulse when the latched key's release is debounced.

Behaviour:
- Reset (rst_n low at a clk edge): rows=4'b1110, row index 0, dwell counter 0, state SCAN, debounce count 0, candidate none, digits=0, opers=0, pressed=0, released=0. Reset mid-debounce or mid-hold abandons the key; no `released` pulse is emitted.
- Synchronization:
  - cols passes through a 2-flop synchronizer before any use.
  - Sampling is done on the last dwell cycle of each row (dwell counter == SCAN_CYCLES-1).
  - After that sample, the row index advances (3 wraps to 0) and rows is updated on the next cycle.
- Key index: row*4 + col. The first low column (lowest col) in scan order is taken.
- Key map:
  - Row0: 1, 2, 3, +
  - Row1: 4, 5, 6, -
  - Row2: 7, 8, 9, *
  - Row3: NEG, 0, EQ, /
- Operator codes: + =1, - =2, * =3, / =4, EQ=5, NEG=6.
- Snapshot: at the end of row 3, the scan snapshot is the lowest-index key found during rows 0-3, or NONE. The snapshot also records whether the current latched key was seen.
- States:
  - SCAN:
    - Snapshot != NONE: candidate=snapshot, count=1, go to DEB_PRESS.
  - DEB_PRESS:
    - Snapshot == candidate: count+1.
    - Count reaches DEBOUNCE_SCANS: latch digits/opers from candidate, pressed=1, go to HELD.
    - Snapshot differs, including NONE: return to SCAN, count=0; a new candidate is taken on the next snapshot.
  - HELD:
    - Other keys are ignored.
    - Latched key absent from snapshot: count=1, go to DEB_REL.
  - DEB_REL:
    - Latched key still absent: count+1.
    - Count reaches DEBOUNCE_SCANS: pressed=0, released=1 for exactly one cycle, go to SCAN.
    - Latched key reappears: go back to HELD, count=0.
- Outputs digits/opers:
  - Change only at press acceptance.
  - Hold their value through release and afterwards, until the next accepted press.
- `released` and the `pressed` fall occur in the same cycle.
- Timing:
  - Press acceptance latency: DEBOUNCE_SCANS full scans after the first sighting.
  - Minimum spacing between `released` and the next `pressed` rise: DEBOUNCE_SCANS scans.
- Both keys down at once: the lower index key wins in SCAN/DEB_PRESS. In HELD, only the latched key matters.
- Counter widths: dwell counter is $clog2(SCAN_CYCLES); debounce count is $clog2(DEBOUNCE_SCANS+1). The debounce count saturates and never wraps.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEB_PRESS, HELD, DEB_REL};
  - key index NONE sentinel (5'h10);
  - operator code constants OP_ADD..OP_NEG;
  - a constant function mapping key index to {digit, oper}.
- One sub-module, `row_sampler`:
  - contents: cols synchronizer, dwell counter, row rotation;
  - emits a per-row sample strobe and a scan-complete strobe.
- The debounce FSM and the output latch remain in keypad_scanner.

Test Plan (SCAN_CYCLES=4, DEBOUNCE_SCANS=3; bench models the matrix, pulling a col low when its row is low):
- Reset: hold rst_n low 3 cycles → rows=1110, digits=0, opers=0, pressed=0, released=0. Then rows walks 1110→1101→1011→0111→1110, one step every 4 cycles.
- Clean press of key "7" (row2, col0) for 6 scans, then release → pressed rises after the 3rd full scan; digits=7, opers=0. After 3 scans of absence, released pulses for exactly 1 cycle and pressed falls in that same cycle; digits stays 7.
- Bounce: "+" down for 1 scan, up for 1 scan, then down for 4 scans → no accept during the bounce; accepted 3 scans after the final down-edge; opers=1, digits=0.
- Release glitch: hold "NEG", release for 1 scan, re-press for 2 scans, then release → no released pulse at the glitch; exactly one released pulse at the final release; opers=6.
- Multi-key: "3" and "5" down simultaneously → digits=3. While "3" is held, releasing "5" and pressing "9" has no effect; releasing "3" emits one released pulse.
- Reset in HELD with "EQ" held → outputs return to reset values and no released pulse; after rst_n rises with "EQ" still down, the key is re-accepted with opers=5 after 3 scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, constants and key map for the keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_e;

    localparam logic [4:0] KEY_NONE = 5'h10;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_EQ  = 4'd5;
    localparam logic [3:0] OP_NEG = 4'd6;

    typedef struct packed {
        logic [3:0] digit;
        logic [3:0] oper;
    } key_code_t;

    // Index is row*4 + col; exactly one of digit/oper is meaningful per key.
    function automatic key_code_t key_decode(input logic [3:0] idx);
        key_code_t kc;
        kc.digit = 4'd0;
        kc.oper  = 4'd0;
        case (idx)
            4'd0:  kc.digit = 4'd1;
            4'd1:  kc.digit = 4'd2;
            4'd2:  kc.digit = 4'd3;
            4'd3:  kc.oper  = OP_ADD;
            4'd4:  kc.digit = 4'd4;
            4'd5:  kc.digit = 4'd5;
            4'd6:  kc.digit = 4'd6;
            4'd7:  kc.oper  = OP_SUB;
            4'd8:  kc.digit = 4'd7;
            4'd9:  kc.digit = 4'd8;
            4'd10: kc.digit = 4'd9;
            4'd11: kc.oper  = OP_MUL;
            4'd12: kc.oper  = OP_NEG;
            4'd13: kc.digit = 4'd0;
            4'd14: kc.oper  = OP_EQ;
            default: kc.oper = OP_DIV;
        endcase
        return kc;
    endfunction

endpackage

// File: rtl/row_sampler.sv
// rtl/row_sampler.sv - row drive rotation, dwell timing and synchronized column sampling
module row_sampler #(
    parameter int SCAN_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       sample_valid,
    output logic [1:0] sample_row,
    output logic [3:0] sample_cols,
    output logic       scan_done
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    rows_q, rows_d;
    logic          last_dwell;

    always_comb begin
        sync1_d    = cols;
        sync2_d    = sync1_q;
        last_dwell = (dwell_q == DWELL_LAST);
        dwell_d    = last_dwell ? '0 : dwell_q + 1'b1;
        row_d      = last_dwell ? row_q + 2'd1 : row_q;
        rows_d     = ~(4'b0001 << row_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            dwell_q <= '0;
            row_q   <= 2'd0;
            rows_q  <= 4'b1110;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dwell_q <= dwell_d;
            row_q   <= row_d;
            rows_q  <= rows_d;
        end
    end

    assign rows         = rows_q;
    assign sample_valid = last_dwell;
    assign sample_row   = row_q;
    assign sample_cols  = sync2_q;
    assign scan_done    = last_dwell && (row_q == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan snapshot, press/release debounce and key code latch
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 50000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] rows,
    input  logic [3:0] cols,
    output logic [3:0] digits,
    output logic [3:0] opers,
    output logic       pressed,
    output logic       released
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

    logic       sample_valid;
    logic [1:0] sample_row;
    logic [3:0] sample_cols;
    logic       scan_done;

    row_sampler #(
        .SCAN_CYCLES(SCAN_CYCLES)
    ) u_row_sampler (
        .clk          (clk),
        .rst_n        (rst_n),
        .cols         (cols),
        .rows         (rows),
        .sample_valid (sample_valid),
        .sample_row   (sample_row),
        .sample_cols  (sample_cols),
        .scan_done    (scan_done)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [4:0]    cand_q, cand_d;
    logic [3:0]    latched_q, latched_d;
    logic [4:0]    best_q, best_d;
    logic          seen_q, seen_d;
    logic [3:0]    digits_q, digits_d;
    logic [3:0]    opers_q, opers_d;
    logic          pressed_q, pressed_d;
    logic          released_q, released_d;

    logic          row_hit;
    logic [1:0]    hit_col;
    logic [4:0]    snap_key;
    logic          snap_seen;
    key_code_t     cand_code;

    // Descending walk so the lowest low column is the one left standing.
    always_comb begin
        row_hit = 1'b0;
        hit_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!sample_cols[c]) begin
                row_hit = 1'b1;
                hit_col = 2'(c);
            end
        end
    end

    // Rows arrive in ascending order, so the first hit of a scan is the lowest index.
    always_comb begin
        snap_key  = best_q;
        snap_seen = seen_q;
        if (sample_valid) begin
            if (row_hit && (best_q == KEY_NONE)) begin
                snap_key = {1'b0, sample_row, hit_col};
            end
            if ((sample_row == latched_q[3:2]) && !sample_cols[latched_q[1:0]]) begin
                snap_seen = 1'b1;
            end
        end
        best_d = scan_done ? KEY_NONE : snap_key;
        seen_d = scan_done ? 1'b0 : snap_seen;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cand_d     = cand_q;
        latched_d  = latched_q;
        digits_d   = digits_q;
        opers_d    = opers_q;
        pressed_d  = pressed_q;
        released_d = 1'b0;
        cnt_inc    = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;
        cand_code  = key_decode(cand_q[3:0]);
        if (scan_done) begin
            case (state_q)
                SCAN: begin
                    if (snap_key != KEY_NONE) begin
                        cand_d  = snap_key;
                        cnt_d   = CW'(1);
                        state_d = DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (snap_key == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            latched_d = cand_q[3:0];
                            digits_d  = cand_code.digit;
                            opers_d   = cand_code.oper;
                            pressed_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = HELD;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                HELD: begin
                    if (!snap_seen) begin
                        cnt_d   = CW'(1);
                        state_d = DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (!snap_seen) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            pressed_d  = 1'b0;
                            released_d = 1'b1;
                            cnt_d      = '0;
                            state_d    = SCAN;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SCAN;
            cnt_q      <= '0;
            cand_q     <= KEY_NONE;
            latched_q  <= 4'd0;
            best_q     <= KEY_NONE;
            seen_q     <= 1'b0;
            digits_q   <= 4'd0;
            opers_q    <= 4'd0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            latched_q  <= latched_d;
            best_q     <= best_d;
            seen_q     <= seen_d;
            digits_q   <= digits_d;
            opers_q    <= opers_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
        end
    end

    assign digits   = digits_q;
    assign opers    = opers_q;
    assign pressed  = pressed_q;
    assign released = released_q;

endmodule
